// File: rtl/ex_operand_stage.sv
// EX-stage operand register: captures decode fields, resolves EX/MEM and MEM/WB
// forwarding for rs/rt, and detects load-use hazards that require a one-cycle stall.
module ex_operand_stage #(
    parameter int LEN_DATA = 16,
    parameter int LEN_REG  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic                id_alu_src,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic [LEN_REG-1:0]  id_rs,
    input  logic [LEN_REG-1:0]  id_rt,
    input  logic [LEN_REG-1:0]  id_rd,
    input  logic [LEN_DATA-1:0] id_rs_data,
    input  logic [LEN_DATA-1:0] id_rt_data,
    input  logic [LEN_DATA-1:0] id_imm,
    input  logic [2:0]          id_alu_op,
    input  logic                flush,
    input  logic                exmem_reg_write,
    input  logic [LEN_REG-1:0]  exmem_rd,
    input  logic [LEN_DATA-1:0] exmem_result,
    input  logic                memwb_reg_write,
    input  logic [LEN_REG-1:0]  memwb_rd,
    input  logic [LEN_DATA-1:0] memwb_result,
    output logic [LEN_DATA-1:0] ex_A,
    output logic [LEN_DATA-1:0] ex_B,
    output logic [LEN_DATA-1:0] ex_store_data,
    output logic [2:0]          ex_sig_op,
    output logic [LEN_REG-1:0]  ex_rd,
    output logic                ex_valid,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                stall
);

    logic                valid_q,     valid_d;
    logic                alu_src_q,   alu_src_d;
    logic                reg_write_q, reg_write_d;
    logic                mem_read_q,  mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [LEN_REG-1:0]  rs_q,        rs_d;
    logic [LEN_REG-1:0]  rt_q,        rt_d;
    logic [LEN_REG-1:0]  rd_q,        rd_d;
    logic [LEN_DATA-1:0] rs_data_q,   rs_data_d;
    logic [LEN_DATA-1:0] rt_data_q,   rt_data_d;
    logic [LEN_DATA-1:0] imm_q,       imm_d;
    logic [2:0]          alu_op_q,    alu_op_d;

    logic                bubble;
    logic [LEN_DATA-1:0] fwd_rs;
    logic [LEN_DATA-1:0] fwd_rt;

    // A load in EX whose destination feeds the instruction in ID cannot be forwarded in time.
    assign stall = id_valid && valid_q && mem_read_q && reg_write_q
                   && (rd_q != '0) && ((rd_q == id_rs) || (rd_q == id_rt));

    assign bubble = flush || stall;

    always_comb begin
        valid_d     = id_valid;
        alu_src_d   = id_alu_src;
        reg_write_d = id_reg_write;
        mem_read_d  = id_mem_read;
        mem_write_d = id_mem_write;
        rs_d        = id_rs;
        rt_d        = id_rt;
        rd_d        = id_rd;
        rs_data_d   = id_rs_data;
        rt_data_d   = id_rt_data;
        imm_d       = id_imm;
        alu_op_d    = id_alu_op;
        if (bubble) begin
            valid_d     = 1'b0;
            alu_src_d   = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            rs_d        = '0;
            rt_d        = '0;
            rd_d        = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_d       = '0;
            alu_op_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            alu_op_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            alu_src_q   <= alu_src_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            alu_op_q    <= alu_op_d;
        end
    end

    // The younger EX/MEM result wins; register 0 is hardwired and never forwarded.
    always_comb begin
        fwd_rs = rs_data_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q)) begin
            fwd_rs = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q)) begin
            fwd_rs = memwb_result;
        end
    end

    always_comb begin
        fwd_rt = rt_data_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q)) begin
            fwd_rt = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q)) begin
            fwd_rt = memwb_result;
        end
    end

    assign ex_A          = fwd_rs;
    assign ex_B          = alu_src_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_sig_op     = alu_op_q;
    assign ex_rd         = rd_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;

endmodule
